// File: rtl/out_channel_pkg.sv
// Shared types and defaults for the executor out-channel drain stage.
package out_channel_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int DefaultWidth      = 12;
  localparam int DefaultDepth      = 8;
  localparam int DefaultCountWidth = 16;

  // One extra pointer bit separates "full" from "empty" when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_channel_fifo.sv
// Register-array FIFO for the out channel: storage, wrapping pointers and push/pop rules.
// A push is taken when requested and either space exists or a pop frees a slot on the same edge.
module out_channel_fifo
  import out_channel_pkg::*;
#(
  parameter int Width = DefaultWidth,
  parameter int Depth = DefaultDepth,
  parameter int PtrWidth = ptr_width(Depth)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_req,
  input  logic [Width-1:0]    push_data,
  input  logic                pop_ready,
  output logic                valid,
  output logic [Width-1:0]    data,
  output logic                full,
  output logic                push_done,
  output logic                pop_done,
  output logic [PtrWidth-1:0] occupancy
);

  localparam int AddrWidth = PtrWidth - 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == PtrWidth'(Depth));
  assign valid     = (occupancy != '0);
  assign data      = mem[rd_ptr[AddrWidth-1:0]];
  assign pop_done  = valid && pop_ready;
  assign push_done = push_req && (!full || pop_done);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_done) wr_ptr <= wr_ptr + 1'b1;
      if (pop_done)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push_done) mem[wr_ptr[AddrWidth-1:0]] <= push_data;
  end

endmodule

// File: rtl/out_channel_drain.sv
// Out-channel drain: buffers executor writes, streams them to the host, flags lost words
// and reports when the channel has drained. Define OUT_CHANNEL_SUM_EN to add the checksum port.
module out_channel_drain
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultWidth,
  parameter int Depth              = DefaultDepth,
  parameter int CountWidth         = DefaultCountWidth
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          finished,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          mValid,
  output logic [MemoryElementWidth-1:0] mData,
  input  logic                          mReady,
  output logic                          full,
  output logic                          overflow,
  output logic                          drained,
  output logic [CountWidth-1:0]         wordCount,
`ifdef OUT_CHANNEL_SUM_EN
  output logic [MemoryElementWidth-1:0] checksum,
`endif
  output state_t                        state
);

  localparam int PtrWidth = ptr_width(Depth);

  logic                push_req;
  logic                push_done;
  logic                pop_done;
  logic [PtrWidth-1:0] occupancy;

  // The executor cannot stall, so writes outside IDLE/RUN are simply lost.
  assign push_req = outWrite && (state == IDLE || state == RUN);

  out_channel_fifo #(
    .Width    (MemoryElementWidth),
    .Depth    (Depth),
    .PtrWidth (PtrWidth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_req  (push_req),
    .push_data (outData),
    .pop_ready (mReady),
    .valid     (mValid),
    .data      (mData),
    .full      (full),
    .push_done (push_done),
    .pop_done  (pop_done),
    .occupancy (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      drained <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (finished)       state <= FLUSH;
          else if (push_done) state <= RUN;
        end
        RUN: begin
          if (finished) state <= FLUSH;
        end
        FLUSH: begin
          // A pop that empties the FIFO on this edge counts as drained.
          if (occupancy == '0 || (occupancy == PtrWidth'(1) && pop_done)) begin
            state   <= DONE;
            drained <= 1'b1;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      wordCount <= '0;
    end else begin
      if (outWrite && !push_done) overflow <= 1'b1;
      if (pop_done && wordCount != '1) wordCount <= wordCount + 1'b1;
    end
  end

`ifdef OUT_CHANNEL_SUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        checksum <= '0;
    else if (pop_done) checksum <= checksum + mData;
  end
`endif

endmodule

// File: tb/tb_out_channel_drain.sv
// Self-checking bench for out_channel_drain: scoreboard of delivered words plus directed checks.
module tb_out_channel_drain;
  import out_channel_pkg::*;

  localparam int W  = 12;
  localparam int D  = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          finished = 1'b0;
  logic          outWrite = 1'b0;
  logic [W-1:0]  outData = '0;
  logic          mValid;
  logic [W-1:0]  mData;
  logic          mReady = 1'b0;
  logic          full;
  logic          overflow;
  logic          drained;
  logic [CW-1:0] wordCount;
`ifdef OUT_CHANNEL_SUM_EN
  logic [W-1:0]  checksum;
`endif
  state_t        state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  out_channel_drain #(
    .MemoryElementWidth (W),
    .Depth              (D),
    .CountWidth         (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .finished  (finished),
    .outWrite  (outWrite),
    .outData   (outData),
    .mValid    (mValid),
    .mData     (mData),
    .mReady    (mReady),
    .full      (full),
    .overflow  (overflow),
    .drained   (drained),
    .wordCount (wordCount),
`ifdef OUT_CHANNEL_SUM_EN
    .checksum  (checksum),
`endif
    .state     (state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard: a handshake is visible at the negedge before the edge that completes it.
  always @(negedge clock) begin
    if (reset && mValid === 1'b1 && mReady === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'(mData), 32'hFFFF_FFFF);
      else                   check("word", 32'(mData), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    outWrite = 1'b0;
    finished = 1'b0;
    mReady   = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    check("rst_mvalid", 32'(mValid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drained", 32'(drained), 0);
    check("rst_count", 32'(wordCount), 0);
    check("rst_state", 32'(state), 32'(IDLE));
  endtask

  task automatic push_word(input logic [W-1:0] w, input bit accept);
    outWrite = 1'b1;
    outData  = w;
    if (accept) exp_q.push_back(w);
    step();
    outWrite = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int budget;
    budget = 0;
    mReady = 1'b1;
    while (mValid && budget < 50) begin
      step();
      budget++;
    end
    check({tag, "_drain_done"}, 32'(mValid), 0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    // Stream 1,2,3 with the consumer always ready, then finish.
    apply_reset();
    mReady = 1'b1;
    for (int i = 1; i <= 3; i++) push_word(W'(i), 1'b1);
    finished = 1'b1;
    step();
    check("t1_count", 32'(wordCount), 3);
    check("t1_drained_early", 32'(drained), 0);
    step();
    check("t1_drained", 32'(drained), 1);
    check("t1_state", 32'(state), 32'(DONE));
`ifdef OUT_CHANNEL_SUM_EN
    check("t1_checksum", 32'(checksum), 6);
`endif

    // Fill, simultaneous push/pop while full, then an overflowing push.
    apply_reset();
    for (int i = 1; i <= D; i++) begin
      push_word(W'(i), 1'b1);
      check("t2_full", 32'(full), (i == D) ? 1 : 0);
    end
    check("t2_mdata_held", 32'(mData), 1);
    mReady = 1'b1;
    push_word(W'(9), 1'b1);
    mReady = 1'b0;
    check("t3_full_kept", 32'(full), 1);
    check("t3_no_overflow", 32'(overflow), 0);
    check("t3_count", 32'(wordCount), 1);
    push_word(W'(10), 1'b0);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_full_after", 32'(full), 1);
    drain_all("t2");
    check("t2_count", 32'(wordCount), D + 1);

    // Random-content burst with a random-ready consumer.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      mReady = ($urandom_range(0, 1) == 1);
      push_word(W'($urandom_range(0, 4095)), 1'b1);
    end
    drain_all("t_rand");
    check("t_rand_count", 32'(wordCount), 6);

    // Finish with nothing pushed, then a protocol-error push after DONE.
    apply_reset();
    finished = 1'b1;
    step();
    check("t4_state_flush", 32'(state), 32'(FLUSH));
    check("t4_drained_early", 32'(drained), 0);
    step();
    check("t4_drained", 32'(drained), 1);
    check("t4_count", 32'(wordCount), 0);
    push_word(W'(5), 1'b0);
    check("t5_overflow", 32'(overflow), 1);
    check("t5_mvalid", 32'(mValid), 0);

    // Asynchronous reset with three words buffered.
    apply_reset();
    for (int i = 1; i <= 3; i++) push_word(W'(i + 20), 1'b1);
    check("t6_mvalid_before", 32'(mValid), 1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("t6_mvalid", 32'(mValid), 0);
    check("t6_full", 32'(full), 0);
    check("t6_overflow", 32'(overflow), 0);
    check("t6_drained", 32'(drained), 0);
    check("t6_count", 32'(wordCount), 0);
`ifdef OUT_CHANNEL_SUM_EN
    check("t6_checksum", 32'(checksum), 0);
`endif
    step();
    reset = 1'b1;
    step();
    check("t6_state", 32'(state), 32'(IDLE));
    check("t6_mvalid_after", 32'(mValid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_channel_drain.md
# out_channel_drain

Downstream stage of the program executor's out channel. It captures each word the executor writes to its output area and buffers it in a small FIFO. It streams the words to a host-side consumer over a valid/ready handshake, and reports when the channel has fully drained after the executor asserts `finished`. The executor cannot stall, so the block never back-pressures it; lost words are flagged instead.

## Interface
Parameters:
- `MemoryElementWidth`, 12, width of one out-channel word
- `Depth`, 8, FIFO entries; power of two, at least 2
- `CountWidth`, 16, width of the delivered-word counter

Ports:
- `clock`  in  1  driving clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `finished`  in  1  executor finished level; held high once set
- `outWrite`  in  1  single-cycle push strobe from executor
- `outData`  in  MemoryElementWidth  word pushed when `outWrite` is high
- `mValid`  out  1  head word available
- `mData`  out  MemoryElementWidth  head word
- `mReady`  in  1  consumer accepts `mData` when high with `mValid`
- `full`  out  1  FIFO holds `Depth` words
- `overflow`  out  1  sticky: at least one push was lost
- `drained`  out  1  high in DONE state
- `wordCount`  out  CountWidth  words delivered (handshakes), saturating
- `checksum`  out  MemoryElementWidth  present only with `OUT_CHANNEL_SUM_EN`

## Operation
- Storage: register array of `Depth` words, read/write pointers of log2(Depth)+1 bits; occupancy = wrPtr − rdPtr.
- `mValid` = occupancy ≠ 0; `mData` = entry at rdPtr (combinational from registers).
- Pop happens when `mValid && mReady`; rdPtr increments, `wordCount` increments, saturating at 2^CountWidth−1.
- Push is accepted when `outWrite` is high, the state is IDLE or RUN, and either the FIFO is not full or a pop happens in the same cycle.
- Push while full with no pop: word dropped, `overflow` set.
- Push in FLUSH or DONE: word dropped, `overflow` set (protocol error).
- Push and pop in the same cycle at any occupancy: both take effect; occupancy unchanged.
- State machine:
  - IDLE (reset state): → RUN on first accepted push; → FLUSH if `finished` is high.
  - RUN: → FLUSH when `finished` is high.
  - FLUSH: → DONE when occupancy is 0 at the clock edge, counting a pop that empties the FIFO on that edge.
  - DONE: terminal until reset.
  - `finished` and `outWrite` high in the same cycle in IDLE or RUN: the push is accepted, then the state moves to FLUSH.
- Pointers wrap modulo 2·Depth; full = occupancy equal to `Depth`.

## Timing
- Reset values: `mValid`=0, `full`=0, `overflow`=0, `drained`=0, `wordCount`=0, `checksum`=0, pointers 0, state IDLE.
- Reset is asynchronous and takes effect mid-transfer; buffered words are discarded.
- Push latency: word pushed at edge t is visible on `mData` with `mValid`=1 right after edge t, when the FIFO was empty.
- `mData` is stable while `mValid && !mReady`.
- `drained` rises one edge after the last word is popped in FLUSH. With zero words pushed, `drained` rises two edges after `finished` is first sampled high: IDLE→FLUSH, then FLUSH→DONE.
- `full` and `overflow` update on the same edge as the push that causes them.

## Configuration
- `OUT_CHANNEL_SUM_EN` defined:
  - `checksum` port exists.
  - It holds the modulo-2^MemoryElementWidth sum of every delivered word (popped, not pushed).
  - It updates on the pop edge and resets to 0.
- Not defined: port and adder absent; all other behaviour is identical.

## Structure
- Shared package `out_channel_pkg`:
  - state enum `{IDLE, RUN, FLUSH, DONE}`
  - default width/depth constants
  - function computing pointer width from `Depth`
- One natural sub-module: `out_channel_fifo`, holding storage, pointers, full/empty and the push/pop rules. The parent holds the state machine, `overflow`, `wordCount` and `checksum`.

## Test plan
- Push 1,2,3 on consecutive cycles with `mReady`=1, then raise `finished` → `mData` 1,2,3 on consecutive cycles, `wordCount`=3, `drained` high one edge after the last pop, `checksum`=6 with the macro defined.
- `mReady`=0; push 8 words, then a 9th → `full`=1 after the 8th push, `overflow`=1 after the 9th; draining yields words 1..8 and never the 9th.
- FIFO full, push and pop in the same cycle → occupancy stays 8, order preserved, `overflow` stays 0.
- Raise `finished` with no pushes → `drained`=1 two edges later, `wordCount`=0.
- After DONE, pulse `outWrite` with value 5 → `overflow`=1, `mValid` stays 0.
- Drop `reset` low mid-drain with 3 words buffered → all outputs return to reset values immediately, without a clock edge; after reset is released, state is IDLE.
